board_sequencer: RTL and testbench
==================================

Name: board_sequencer

Overview:
- Parametrised successor to the avionics top-level on/off state machine.
- Sequences the board through IDLE, STARTUP, RUNNING, SHUTDOWN and FAULT.
- Gates N_SUB subsystems with enable/ready/fault handshakes, with tick-based timeouts on startup and shutdown.
- Owns the board tick prescaler, RUNNING timestamp and LED status pattern; instantiated once at top level, fed by the debounced button.

Parameters:
- TICK_DIV, 50000, clk cycles per tick (50 MHz -> 1 kHz); must be >= 2.
- TS_WIDTH, 24, timestamp width.
- N_SUB, 4, number of subsystems handshaked.
- STARTUP_TICKS, 2000, ticks allowed for all sub_ready to assert.
- SHUTDOWN_TICKS, 2000, ticks allowed for all sub_ready to deassert.
- BLINK_TICKS, 100, ticks per LED blink half-period.
- LED_LSB, 5, timestamp bit shown on led[0] in RUNNING; LED_LSB+7 < TS_WIDTH.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- btn  in  1  debounced on/off button, level, active-high
- sub_ready  in  N_SUB  per-subsystem ready (high = up)
- sub_fault  in  N_SUB  per-subsystem fault, level
- sub_enable  out  N_SUB  enable to subsystems, all bits equal
- state  out  3  0 IDLE, 1 STARTUP, 2 RUNNING, 3 SHUTDOWN, 4 FAULT
- tick  out  1  one-cycle pulse every TICK_DIV clocks
- timestamp  out  TS_WIDTH  ticks elapsed in RUNNING
- fault_src  out  N_SUB  sub_fault snapshot latched on FAULT entry
- fault_timeout  out  1  FAULT entered via timeout
- led  out  8  status pattern

Behaviour:
- Reset:
  - state=IDLE, sub_enable=0, tick=0, timestamp=0, fault_src=0, fault_timeout=0, led=0.
  - Prescaler, timeout counter and blink counter are zeroed; blink=0.
  - btn_q is set to 1, so a button held through reset is not a press.
- Press: press = btn & ~btn_q, where btn_q is btn registered each clk.
- Tick:
  - Prescaler counts 0..TICK_DIV-1 and wraps; tick=1 for the single cycle in which it equals TICK_DIV-1.
  - Prescaler is free-running and is not affected by state.
- Timeout counter:
  - Cleared on every state change; increments on tick.
  - Expiry = counter reaches the limit (STARTUP_TICKS or SHUTDOWN_TICKS) while in the relevant state.
- Transitions (registered; all outputs update on the same edge as state):
  - IDLE: press -> STARTUP.
  - STARTUP:
    - any sub_fault -> FAULT.
    - else &sub_ready -> RUNNING.
    - else press -> SHUTDOWN (abort).
    - else expiry -> FAULT with fault_timeout=1.
  - RUNNING:
    - any sub_fault -> FAULT.
    - else press -> SHUTDOWN.
    - else ~|sub_ready is ignored.
  - SHUTDOWN:
    - ~|sub_ready -> IDLE.
    - else expiry -> FAULT with fault_timeout=1.
    - press is ignored; sub_fault is ignored.
  - FAULT: press -> IDLE, clearing fault_src and fault_timeout.
- Priority on the same cycle: fault > ready/complete > press > timeout.
- FAULT entry: fault_src <= sub_fault sampled on the entry cycle (zero on timeout entry).
- sub_enable: all ones in STARTUP and RUNNING, zero otherwise; drops on the same edge state leaves RUNNING.
- Timestamp:
  - Held at 0 outside RUNNING and zeroed on RUNNING entry.
  - Increments on tick while in RUNNING; wraps modulo 2^TS_WIDTH with no flag.
- Blink: toggles every BLINK_TICKS ticks, free-running.
- LED:
  - IDLE: 8'h00.
  - STARTUP and SHUTDOWN: {8{blink}}.
  - RUNNING: timestamp[LED_LSB+7:LED_LSB].
  - FAULT: blink ? 8'hAA : 8'h55.
- rst mid-operation: immediate return to the reset state on the next edge, including sub_enable=0.

Test Plan:
- Use TICK_DIV=4, STARTUP_TICKS=5, SHUTDOWN_TICKS=5, BLINK_TICKS=2, LED_LSB=0, N_SUB=2, TS_WIDTH=8.
- Power-on with btn held high through reset, then released and pressed -> only the post-reset press moves IDLE->STARTUP; sub_enable=2'b11 on that edge.
- In STARTUP, raise sub_ready to 2'b11 after 3 ticks -> RUNNING; timestamp=0, then 1,2,3 on successive ticks; led equals the timestamp.
- In STARTUP, hold sub_ready=2'b01 -> FAULT after the 5th tick; fault_timeout=1, fault_src=0, led alternates AA/55 every 2 ticks; press -> IDLE with flags clear.
- In RUNNING, sub_fault=2'b10 on the same cycle as a press -> FAULT (not SHUTDOWN); fault_src=2'b10, sub_enable=0.
- Run 256 ticks in RUNNING -> timestamp wraps 255->0. Then press -> SHUTDOWN, timestamp=0; sub_ready=0 after 2 ticks -> IDLE.
- Assert rst while in RUNNING with timestamp=0x40 -> next edge gives state=IDLE, timestamp=0, sub_enable=0, led=0.

Source files
------------

// File: rtl/board_sequencer.sv
// Board on/off sequencer: IDLE/STARTUP/RUNNING/SHUTDOWN/FAULT with
// subsystem handshakes, tick prescaler, run timestamp and status LEDs.
module board_sequencer #(
    parameter int TICK_DIV       = 50000,
    parameter int TS_WIDTH       = 24,
    parameter int N_SUB          = 4,
    parameter int STARTUP_TICKS  = 2000,
    parameter int SHUTDOWN_TICKS = 2000,
    parameter int BLINK_TICKS    = 100,
    parameter int LED_LSB        = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn,
    input  logic [N_SUB-1:0]    sub_ready,
    input  logic [N_SUB-1:0]    sub_fault,
    output logic [N_SUB-1:0]    sub_enable,
    output logic [2:0]          state,
    output logic                tick,
    output logic [TS_WIDTH-1:0] timestamp,
    output logic [N_SUB-1:0]    fault_src,
    output logic                fault_timeout,
    output logic [7:0]          led
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_STARTUP  = 3'd1;
    localparam logic [2:0] S_RUNNING  = 3'd2;
    localparam logic [2:0] S_SHUTDOWN = 3'd3;
    localparam logic [2:0] S_FAULT    = 3'd4;

    localparam int TO_MAX = (STARTUP_TICKS > SHUTDOWN_TICKS) ?
                            STARTUP_TICKS : SHUTDOWN_TICKS;
    localparam int TO_W = $clog2(TO_MAX + 1);
    localparam int PS_W = $clog2(TICK_DIV);
    localparam int BL_W = $clog2(BLINK_TICKS + 1);

    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(TICK_DIV - 1);
    localparam logic [BL_W-1:0] BL_LAST  = BL_W'(BLINK_TICKS - 1);
    localparam logic [TO_W-1:0] TO_START = TO_W'(STARTUP_TICKS);
    localparam logic [TO_W-1:0] TO_SHUT  = TO_W'(SHUTDOWN_TICKS);
    localparam logic [TO_W-1:0] TO_SAT   = TO_W'(TO_MAX);

    logic            btn_q;
    logic            press;
    logic [PS_W-1:0] presc;
    logic [TO_W-1:0] tcnt;
    logic [BL_W-1:0] bcnt;
    logic            blink;
    logic [2:0]      state_d;
    logic            to_hit;
    logic            enter_fault;
    logic            leave_fault;
    logic            in_run;

    assign press = btn & ~btn_q;
    assign tick  = (presc == PS_LAST);

    assign enter_fault = (state_d == S_FAULT) && (state != S_FAULT);
    assign leave_fault = (state == S_FAULT) && (state_d != S_FAULT);
    assign in_run      = (state_d == S_RUNNING) && (state == S_RUNNING);

    assign sub_enable = {N_SUB{(state == S_STARTUP) ||
                               (state == S_RUNNING)}};

    // Next-state decode; priority is fault > ready/complete > press > timeout.
    always_comb begin
        state_d = state;
        to_hit  = 1'b0;
        case (state)
            S_IDLE: begin
                if (press)
                    state_d = S_STARTUP;
            end
            S_STARTUP: begin
                if (|sub_fault)
                    state_d = S_FAULT;
                else if (&sub_ready)
                    state_d = S_RUNNING;
                else if (press)
                    state_d = S_SHUTDOWN;
                else if (tcnt == TO_START) begin
                    state_d = S_FAULT;
                    to_hit  = 1'b1;
                end
            end
            S_RUNNING: begin
                if (|sub_fault)
                    state_d = S_FAULT;
                else if (press)
                    state_d = S_SHUTDOWN;
            end
            S_SHUTDOWN: begin
                if (~|sub_ready)
                    state_d = S_IDLE;
                else if (tcnt == TO_SHUT) begin
                    state_d = S_FAULT;
                    to_hit  = 1'b1;
                end
            end
            S_FAULT: begin
                if (press)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register, button edge history and free-running prescaler.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            btn_q <= 1'b1;
            presc <= '0;
        end else begin
            state <= state_d;
            btn_q <= btn;
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    // Timeout ticks spent in the current state; saturates at the largest limit.
    always_ff @(posedge clk) begin
        if (rst)
            tcnt <= '0;
        else if (state_d != state)
            tcnt <= '0;
        else if (tick && (tcnt != TO_SAT))
            tcnt <= tcnt + 1'b1;
    end

    // Free-running LED blink, toggling every BLINK_TICKS ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt  <= '0;
            blink <= 1'b0;
        end else if (tick) begin
            if (bcnt == BL_LAST) begin
                bcnt  <= '0;
                blink <= ~blink;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

    // Timestamp only advances while staying in RUNNING; zero elsewhere.
    always_ff @(posedge clk) begin
        if (rst)
            timestamp <= '0;
        else if (in_run)
            timestamp <= timestamp + TS_WIDTH'(tick);
        else
            timestamp <= '0;
    end

    // Fault cause is captured on entry and cleared when FAULT is left.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_src     <= '0;
            fault_timeout <= 1'b0;
        end else if (enter_fault) begin
            fault_src     <= to_hit ? '0 : sub_fault;
            fault_timeout <= to_hit;
        end else if (leave_fault) begin
            fault_src     <= '0;
            fault_timeout <= 1'b0;
        end
    end

    // LED status pattern selected by the current state.
    always_comb begin
        led = 8'h00;
        case (state)
            S_STARTUP,
            S_SHUTDOWN: led = {8{blink}};
            S_RUNNING:  led = timestamp[LED_LSB +: 8];
            S_FAULT:    led = blink ? 8'hAA : 8'h55;
            default:    led = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_board_sequencer.sv
// Directed bench for board_sequencer: vector table plus hand-timed
// sequences for wrap, shutdown, abort, timeout and mid-run reset.
module tb_board_sequencer;

    localparam logic [2:0] IDL = 3'd0;
    localparam logic [2:0] STU = 3'd1;
    localparam logic [2:0] RUN = 3'd2;
    localparam logic [2:0] SHD = 3'd3;
    localparam logic [2:0] FLT = 3'd4;

    logic       clk;
    logic       rst;
    logic       btn;
    logic [1:0] sub_ready;
    logic [1:0] sub_fault;
    logic [1:0] sub_enable;
    logic [2:0] state;
    logic       tick;
    logic [7:0] timestamp;
    logic [1:0] fault_src;
    logic       fault_timeout;
    logic [7:0] led;

    int errors = 0;
    int checks = 0;

    board_sequencer #(
        .TICK_DIV(4),
        .TS_WIDTH(8),
        .N_SUB(2),
        .STARTUP_TICKS(5),
        .SHUTDOWN_TICKS(5),
        .BLINK_TICKS(2),
        .LED_LSB(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .sub_ready(sub_ready),
        .sub_fault(sub_fault),
        .sub_enable(sub_enable),
        .state(state),
        .tick(tick),
        .timestamp(timestamp),
        .fault_src(fault_src),
        .fault_timeout(fault_timeout),
        .led(led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       btn;
        logic [1:0] rdy;
        logic [1:0] flt;
        int         n;
        logic [2:0] st;
        logic [1:0] en;
        int         led;
        logic [7:0] ts;
        logic [1:0] fsrc;
        logic       fto;
    } vec_t;

    function automatic vec_t mk(logic r, logic b, logic [1:0] rd,
                                logic [1:0] fl, int n, logic [2:0] st,
                                logic [1:0] en, int ld, logic [7:0] ts,
                                logic [1:0] fs, logic fto);
        vec_t v;
        v.rst = r;  v.btn = b;  v.rdy = rd; v.flt = fl; v.n = n;
        v.st = st;  v.en = en;  v.led = ld; v.ts = ts;
        v.fsrc = fs; v.fto = fto;
        return v;
    endfunction

    task automatic cmp(input string nm, input string f,
                       input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s.%s got=%0h want=%0h", nm, f, got, want);
        end
    endtask

    task automatic chk(input string nm, input logic [2:0] st,
                       input logic [1:0] en, input int ld,
                       input logic [7:0] ts, input logic [1:0] fs,
                       input logic fto);
        cmp(nm, "state", int'(state), int'(st));
        cmp(nm, "sub_enable", int'(sub_enable), int'(en));
        if (ld >= 0)
            cmp(nm, "led", int'(led), ld);
        cmp(nm, "timestamp", int'(timestamp), int'(ts));
        cmp(nm, "fault_src", int'(fault_src), int'(fs));
        cmp(nm, "fault_timeout", int'(fault_timeout), int'(fto));
    endtask

    task automatic drive(input logic b, input logic [1:0] r,
                         input logic [1:0] f, input int n);
        btn = b;
        sub_ready = r;
        sub_fault = f;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];

        rst = 1'b1;
        btn = 1'b1;
        sub_ready = 2'b00;
        sub_fault = 2'b00;

        vecs.push_back(mk(1,1,2'b00,2'b00, 2,IDL,2'b00,8'h00,0,2'b00,0));
        vecs.push_back(mk(0,1,2'b00,2'b00, 2,IDL,2'b00,8'h00,0,2'b00,0));
        vecs.push_back(mk(0,0,2'b00,2'b00, 1,IDL,2'b00,8'h00,0,2'b00,0));
        vecs.push_back(mk(0,1,2'b00,2'b00, 1,STU,2'b11,8'h00,0,2'b00,0));
        vecs.push_back(mk(0,1,2'b01,2'b00, 4,STU,2'b11,8'hFF,0,2'b00,0));
        vecs.push_back(mk(0,1,2'b01,2'b00,12,STU,2'b11,8'h00,0,2'b00,0));
        vecs.push_back(mk(0,1,2'b01,2'b00, 4,STU,2'b11,8'hFF,0,2'b00,0));
        vecs.push_back(mk(0,1,2'b01,2'b00, 1,FLT,2'b00,8'hAA,0,2'b00,1));
        vecs.push_back(mk(0,1,2'b01,2'b00, 7,FLT,2'b00,8'h55,0,2'b00,1));
        vecs.push_back(mk(0,0,2'b01,2'b00, 1,FLT,2'b00,8'h55,0,2'b00,1));
        vecs.push_back(mk(0,1,2'b01,2'b00, 1,IDL,2'b00,8'h00,0,2'b00,0));
        vecs.push_back(mk(0,0,2'b00,2'b00, 1,IDL,2'b00,8'h00,0,2'b00,0));
        vecs.push_back(mk(0,1,2'b00,2'b00, 1,STU,2'b11,8'h00,0,2'b00,0));
        vecs.push_back(mk(0,1,2'b00,2'b00,12,STU,2'b11,8'h00,0,2'b00,0));
        vecs.push_back(mk(0,1,2'b11,2'b00, 1,RUN,2'b11,8'h00,0,2'b00,0));
        vecs.push_back(mk(0,1,2'b11,2'b00, 2,RUN,2'b11,8'h00,0,2'b00,0));
        vecs.push_back(mk(0,1,2'b11,2'b00, 1,RUN,2'b11,8'h01,1,2'b00,0));
        vecs.push_back(mk(0,1,2'b11,2'b00, 4,RUN,2'b11,8'h02,2,2'b00,0));
        vecs.push_back(mk(0,1,2'b11,2'b00, 4,RUN,2'b11,8'h03,3,2'b00,0));
        vecs.push_back(mk(0,1,2'b00,2'b00, 4,RUN,2'b11,8'h04,4,2'b00,0));
        vecs.push_back(mk(0,0,2'b11,2'b00, 1,RUN,2'b11,8'h04,4,2'b00,0));
        vecs.push_back(mk(0,1,2'b11,2'b10, 1,FLT,2'b00,8'h55,0,2'b10,0));
        vecs.push_back(mk(0,0,2'b11,2'b00, 1,FLT,2'b00,8'h55,0,2'b10,0));
        vecs.push_back(mk(0,1,2'b11,2'b00, 1,IDL,2'b00,8'h00,0,2'b00,0));

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            drive(vecs[i].btn, vecs[i].rdy, vecs[i].flt, vecs[i].n);
            chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].en,
                vecs[i].led, vecs[i].ts, vecs[i].fsrc, vecs[i].fto);
        end

        // Timestamp wrap, then shutdown with faults ignored.
        drive(0, 2'b11, 2'b00, 1);
        drive(1, 2'b11, 2'b00, 1);
        chk("wrap_start", STU, 2'b11, -1, 0, 2'b00, 0);
        drive(1, 2'b11, 2'b00, 1);
        chk("wrap_run", RUN, 2'b11, 8'h00, 0, 2'b00, 0);
        drive(1, 2'b11, 2'b00, 1017);
        chk("wrap_255", RUN, 2'b11, 8'hFF, 8'hFF, 2'b00, 0);
        drive(1, 2'b11, 2'b00, 4);
        chk("wrap_0", RUN, 2'b11, 8'h00, 8'h00, 2'b00, 0);
        drive(0, 2'b11, 2'b00, 1);
        drive(1, 2'b11, 2'b00, 1);
        chk("shd_enter", SHD, 2'b00, -1, 0, 2'b00, 0);
        drive(1, 2'b11, 2'b01, 6);
        chk("shd_hold", SHD, 2'b00, -1, 0, 2'b00, 0);
        drive(1, 2'b00, 2'b00, 1);
        chk("shd_done", IDL, 2'b00, 8'h00, 0, 2'b00, 0);

        // Reset in the middle of RUNNING at timestamp 0x40.
        drive(0, 2'b00, 2'b00, 1);
        drive(1, 2'b11, 2'b00, 1);
        drive(1, 2'b11, 2'b00, 1);
        chk("rr_run", RUN, 2'b11, 8'h00, 0, 2'b00, 0);
        drive(1, 2'b11, 2'b00, 256);
        chk("rr_40", RUN, 2'b11, 8'h40, 8'h40, 2'b00, 0);
        rst = 1'b1;
        drive(1, 2'b11, 2'b00, 1);
        chk("rr_rst", IDL, 2'b00, 8'h00, 0, 2'b00, 0);
        cmp("rr_rst", "tick", int'(tick), 0);
        rst = 1'b0;
        drive(1, 2'b11, 2'b00, 2);
        cmp("tick_e2", "tick", int'(tick), 0);
        drive(1, 2'b11, 2'b00, 1);
        cmp("tick_e3", "tick", int'(tick), 1);
        drive(1, 2'b11, 2'b00, 1);
        cmp("tick_e4", "tick", int'(tick), 0);
        chk("rr_held", IDL, 2'b00, 8'h00, 0, 2'b00, 0);

        // STARTUP abort by press, then fault beating ready.
        drive(0, 2'b00, 2'b00, 1);
        drive(1, 2'b00, 2'b00, 1);
        drive(0, 2'b00, 2'b00, 1);
        drive(1, 2'b00, 2'b00, 1);
        chk("abort", SHD, 2'b00, -1, 0, 2'b00, 0);
        drive(1, 2'b00, 2'b00, 1);
        chk("abort_idle", IDL, 2'b00, 8'h00, 0, 2'b00, 0);
        drive(0, 2'b00, 2'b00, 1);
        drive(1, 2'b00, 2'b00, 1);
        drive(1, 2'b11, 2'b01, 1);
        chk("stu_fault", FLT, 2'b00, -1, 0, 2'b01, 0);
        drive(0, 2'b11, 2'b00, 1);
        drive(1, 2'b11, 2'b00, 1);
        chk("stu_clear", IDL, 2'b00, 8'h00, 0, 2'b00, 0);

        // SHUTDOWN timeout with sub_fault ignored and not captured.
        drive(0, 2'b11, 2'b00, 1);
        drive(1, 2'b11, 2'b00, 1);
        drive(1, 2'b11, 2'b00, 1);
        drive(0, 2'b11, 2'b00, 1);
        drive(1, 2'b11, 2'b00, 1);
        chk("sto_enter", SHD, 2'b00, -1, 0, 2'b00, 0);
        drive(1, 2'b11, 2'b01, 17);
        chk("sto_edge", SHD, 2'b00, -1, 0, 2'b00, 0);
        drive(1, 2'b11, 2'b01, 1);
        chk("sto_fault", FLT, 2'b00, -1, 0, 2'b00, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
